// File: rtl/polyvec_ntt_seq.sv
// -----------------------------------------------------------------------------
// polyvec_ntt_seq
//
// Runs one shared single-polynomial NTT/INTT core over every polynomial of a
// VEC_LEN-long polynomial vector. The whole input vector is captured when a
// request is accepted. Polynomials are then handed to the core one at a time,
// and each result is written back into the output vector register.
//
// Configuration macro: POLYVEC_NTT_SEQ_INV_EN
//   defined     -> `mode` is honoured; core_inv follows the latched mode.
//   not defined -> `mode` is ignored; core_inv is always 0 (forward only).
//
// Ports (POLY_W = N*COEF_W):
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   rtr       in   start request (level, held until rts is seen)
//   mode      in   0 = forward, 1 = inverse; sampled with rtr
//   v_in      in   input vector, poly i at [i*POLY_W +: POLY_W]
//   v_out     out  result vector, same packing
//   rts       out  result valid (DONE state)
//   busy      out  high in every state except IDLE
//   idx       out  index of the polynomial in process
//   core_rtr  out  request to the core (RUN state)
//   core_inv  out  core direction select
//   core_inp  out  core operand, registered and stable through RUN
//   core_out  in   core result
//   core_rts  in   core result valid
// -----------------------------------------------------------------------------
module polyvec_ntt_seq #(
  parameter int VEC_LEN = 5,
  parameter int N       = 256,
  parameter int COEF_W  = 32,
  localparam int POLY_W = N * COEF_W,
  localparam int VEC_W  = VEC_LEN * POLY_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rtr,
  input  logic              mode,
  input  logic [VEC_W-1:0]  v_in,
  output logic [VEC_W-1:0]  v_out,
  output logic              rts,
  output logic              busy,
  output logic [2:0]        idx,
  output logic              core_rtr,
  output logic              core_inv,
  output logic [POLY_W-1:0] core_inp,
  input  logic [POLY_W-1:0] core_out,
  input  logic              core_rts
);

`ifdef POLYVEC_NTT_SEQ_INV_EN
  localparam logic INV_EN = 1'b1;
`else
  localparam logic INV_EN = 1'b0;
`endif

  localparam logic [2:0] LAST_IDX = 3'(VEC_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [VEC_W-1:0]    vec_r;
  logic [VEC_W-1:0]    v_out_r;
  logic [POLY_W-1:0]   core_inp_r;
  logic [2:0]          idx_r;
  logic                mode_r;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rtr) state_s = ST_LOAD;
        else     state_s = ST_IDLE;
      end
      ST_LOAD: begin
        state_s = ST_RUN;
      end
      ST_RUN: begin
        if (core_rts) state_s = ST_DRAIN;
        else          state_s = ST_RUN;
      end
      ST_DRAIN: begin
        // Wait for the core to drop its valid so a held core_rts is never
        // mistaken for the next polynomial's result.
        if (!core_rts) begin
          if (idx_r == LAST_IDX) state_s = ST_DONE;
          else                   state_s = ST_LOAD;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!rtr) state_s = ST_IDLE;
        else      state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: vector capture, operand load, result write-back, index.
  always_ff @(posedge clock) begin
    if (reset) begin
      vec_r      <= '0;
      v_out_r    <= '0;
      core_inp_r <= '0;
      idx_r      <= 3'd0;
      mode_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rtr) begin
            vec_r  <= v_in;
            // With the inverse feature compiled out this stays 0 forever.
            mode_r <= mode & INV_EN;
            idx_r  <= 3'd0;
          end
        end
        ST_LOAD: begin
          core_inp_r <= vec_r[int'(idx_r) * POLY_W +: POLY_W];
        end
        ST_RUN: begin
          if (core_rts) begin
            v_out_r[int'(idx_r) * POLY_W +: POLY_W] <= core_out;
          end
        end
        ST_DRAIN: begin
          if (!core_rts && (idx_r != LAST_IDX)) begin
            idx_r <= idx_r + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control outputs decode directly from the state register.
  assign rts      = (state_r == ST_DONE);
  assign busy     = (state_r != ST_IDLE);
  assign core_rtr = (state_r == ST_RUN);
  assign core_inv = mode_r;
  assign core_inp = core_inp_r;
  assign idx      = idx_r;
  assign v_out    = v_out_r;

endmodule

// File: doc/polyvec_ntt_seq.md
# polyvec_ntt_seq

Parametrised vector sequencer that runs an external single-polynomial NTT core over every polynomial of a length-`VEC_LEN` polynomial vector. It supports forward and optional inverse transform modes. It sits between the key-generation control FSM and one shared NTT/INTT core. It captures the whole input vector on start, streams polynomials to the core one at a time, collects results into an output vector register, and signals completion with the team's rtr/rts level handshake.

## Interface
Parameters:
- `VEC_LEN`, default 5: polynomials per vector (legal range 1..8).
- `N`, default 256: coefficients per polynomial.
- `COEF_W`, default 32: signed coefficient width.

Ports (`POLY_W` = `N*COEF_W`):
- `clock` in, 1: clock; all logic on the rising edge.
- `reset` in, 1: reset, synchronous, active-high.
- `rtr` in, 1: start request; level, held until `rts` is seen.
- `mode` in, 1: 0 = forward NTT, 1 = inverse NTT; sampled with `rtr`.
- `v_in` in, `VEC_LEN*POLY_W`: input vector; poly i at bits [i*POLY_W +: POLY_W].
- `v_out` out, `VEC_LEN*POLY_W`: result vector, same packing.
- `rts` out, 1: result valid; high in DONE only.
- `busy` out, 1: high in every state except IDLE.
- `idx` out, 3: index of the polynomial currently in process.
- `core_rtr` out, 1: request to the core.
- `core_inv` out, 1: core direction select.
- `core_inp` out, `POLY_W`: core operand; registered.
- `core_out` in, `POLY_W`: core result.
- `core_rts` in, 1: core result valid.

## Operation
State machine:
- **IDLE**
  - When `rtr`=1: capture `v_in` into an internal vector register, latch `mode`, set `idx`<=0, go to LOAD.
- **LOAD** (1 cycle)
  - `core_inp` <= captured poly[`idx`]; go to RUN.
- **RUN**
  - `core_rtr`=1.
  - On `core_rts`=1: `v_out` poly[`idx`] <= `core_out`; go to DRAIN.
- **DRAIN**
  - `core_rtr`=0; wait for `core_rts`=0.
  - Then: if `idx`==`VEC_LEN`-1, go to DONE; else `idx`<=`idx`+1 and go to LOAD.
- **DONE**
  - `rts`=1.
  - When `rtr`=0: go to IDLE.

Data rules:
- `core_inp` stays stable throughout RUN.
- Only poly[`idx`] of `v_out` is written per pass; all other slices hold their values.
- Coefficients pass through bit-exact; the block performs no arithmetic.
- `core_inv` = latched mode for the whole run.

Boundary conditions:
- `rtr` falling before DONE is ignored; the run completes, and DONE then lasts exactly 1 cycle.
- Changes on `v_in` or `mode` after capture have no effect.
- `core_rts`=1 on the first RUN cycle is legal and is captured immediately.
- `VEC_LEN`=1: a single LOAD/RUN/DRAIN pass.
- `reset` mid-run: the next state is IDLE with all outputs at reset values; no partial result is flagged.

## Timing
Reset values:
- `rts`, `busy`, `core_rtr`, `core_inv` = 0.
- `idx` = 0.
- `core_inp` = 0 and `v_out` = 0.

Registration:
- All outputs are registered, or decoded from the state register only.

Latency, from the `rtr` sample to `rts` high:
- Let C = core cycles from `core_rtr` rise to `core_rts` rise, and D = DRAIN cycles.
- Latency = 1 + `VEC_LEN`*(1 + (C+1) + D) cycles.
- With C=10, D=1, `VEC_LEN`=5, latency = 66 cycles.

Handshake gaps:
- `core_rtr` is low for at least 2 cycles between polynomials (DRAIN + LOAD).
- A new run starts no earlier than 1 cycle after `rtr` is seen low in DONE.

## Configuration
- `POLYVEC_NTT_SEQ_INV_EN` defined: `mode` is honoured, and `core_inv` follows the latched mode.
- Not defined: `mode` is ignored, `core_inv` is tied to 0, and only forward transforms run.

## Test plan
- **Forward run.** Stub core returns input+1 per coefficient with C=10; `VEC_LEN`=5, `v_in` poly i = all i.
  - `v_out` poly i = all i+1.
  - `rts` rises 66 cycles after the `rtr` sample.
  - `idx` steps 0..4.
- **Inverse mode.** `mode`=1 with the macro defined: `core_inv`=1 for the entire run. Without the macro: `core_inv`=0.
- **Early `rtr` drop and stale input.** Drop `rtr` during poly 2 and change `v_in`.
  - Results match the captured `v_in`.
  - `rts` is high for exactly 1 cycle, then IDLE.
- **Slow `core_rts` fall.** Core holds `core_rts` high for 4 cycles.
  - DRAIN lasts 4 cycles and `core_rtr` stays 0.
  - Each poly is captured exactly once.
- **Reset mid-run.** Assert `reset` during poly 3 RUN.
  - Next cycle: `core_rtr`=0, `busy`=0, `v_out`=0.
  - A new run completes correctly.
- **`VEC_LEN`=1 with C=0.** `core_rts` is tied high.
  - `rts` after 1+1+1+D cycles.
  - Block waits in DRAIN until the stub lowers `core_rts`.
